snake_body_store: RTL and testbench



---
 rtl/snake_body_store.sv | 256 +++++++++++++++++++++++++
 tb/tb_snake_body_store.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_store.sv
// Snake segment store: steps the head one cell, scans for wall/self/apple hits, then shifts the body.
// Define SNAKE_WRAP_EN to wrap the head around the screen edges instead of dying at the walls.
module snake_body_store #(
    parameter int MAX_LEN  = 8,
    parameter int IDXW     = 4,
    parameter int INIT_LEN = 4,
    parameter int CELL     = 10,
    parameter int XSCREEN  = 160,
    parameter int YSCREEN  = 120,
    parameter int X0       = 80,
    parameter int Y0       = 60
) (
    input  logic            CLOCK_50,
    input  logic            Resetn,
    input  logic            init,
    input  logic            step,
    input  logic [1:0]      dir,
    input  logic [7:0]      apple_x,
    input  logic [6:0]      apple_y,
    input  logic [IDXW-1:0] rd_idx,
    output logic [7:0]      rd_x,
    output logic [6:0]      rd_y,
    output logic            rd_valid,
    output logic [IDXW-1:0] length,
    output logic            busy,
    output logic            done,
    output logic            ate,
    output logic            dead
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WALL  = 3'd1,
        S_SCAN  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Heading codes: a reversal is always the bitwise inverse of the current heading.
    localparam logic [1:0] H_RIGHT = 2'b00;
    localparam logic [1:0] H_DOWN  = 2'b01;
    localparam logic [1:0] H_UP    = 2'b10;
    localparam logic [1:0] H_LEFT  = 2'b11;

    localparam logic [7:0] CELL_X = 8'(CELL);
    localparam logic [6:0] CELL_Y = 7'(CELL);
    localparam logic [7:0] X_MAX  = 8'(XSCREEN - CELL);
    localparam logic [6:0] Y_MAX  = 7'(YSCREEN - CELL);

    state_t state;
    state_t state_next;

    logic [7:0]      seg_x [MAX_LEN];
    logic [6:0]      seg_y [MAX_LEN];
    logic [1:0]      heading;
    logic [7:0]      nh_x;
    logic [6:0]      nh_y;
    logic            wall_hit;
    logic            ate_r;
    logic [IDXW-1:0] scan_idx;
    logic [IDXW-1:0] scan_last;

    logic            accept;
    logic [1:0]      eff_dir;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;
    logic [7:0]      cand_x;
    logic [6:0]      cand_y;
    logic            cand_wall;
    logic            ate_next;
    logic            grow_ok;
    logic [IDXW-1:0] last_next;
    logic [IDXW-1:0] new_len;
    logic [7:0]      cur_x;
    logic [6:0]      cur_y;
    logic            body_hit;

    assign accept  = (state == S_IDLE) && step && !dead;
    assign eff_dir = (dir == ~heading) ? heading : dir;

    // Candidate head; the 9/8-bit sums and the pre-subtract compares catch both screen edges.
    always_comb begin
        sum_x     = {1'b0, seg_x[0]} + {1'b0, CELL_X};
        sum_y     = {1'b0, seg_y[0]} + {1'b0, CELL_Y};
        cand_x    = seg_x[0];
        cand_y    = seg_y[0];
        cand_wall = 1'b0;
        case (eff_dir)
            H_RIGHT: begin
                if (sum_x > {1'b0, X_MAX}) begin
`ifdef SNAKE_WRAP_EN
                    cand_x = '0;
`else
                    cand_wall = 1'b1;
`endif
                end else begin
                    cand_x = sum_x[7:0];
                end
            end
            H_DOWN: begin
                if (sum_y > {1'b0, Y_MAX}) begin
`ifdef SNAKE_WRAP_EN
                    cand_y = '0;
`else
                    cand_wall = 1'b1;
`endif
                end else begin
                    cand_y = sum_y[6:0];
                end
            end
            H_UP: begin
                if (seg_y[0] < CELL_Y) begin
`ifdef SNAKE_WRAP_EN
                    cand_y = Y_MAX;
`else
                    cand_wall = 1'b1;
`endif
                end else begin
                    cand_y = seg_y[0] - CELL_Y;
                end
            end
            default: begin
                if (seg_x[0] < CELL_X) begin
`ifdef SNAKE_WRAP_EN
                    cand_x = X_MAX;
`else
                    cand_wall = 1'b1;
`endif
                end else begin
                    cand_x = seg_x[0] - CELL_X;
                end
            end
        endcase
    end

    // When the snake does not grow the tail moves away, so the last segment is not compared.
    assign ate_next  = (nh_x == apple_x) && (nh_y == apple_y);
    assign grow_ok   = (length < IDXW'(MAX_LEN));
    assign last_next = (ate_next && grow_ok) ? length - IDXW'(1) : length - IDXW'(2);
    assign new_len   = (ate_r && grow_ok) ? length + IDXW'(1) : length;

    always_comb begin
        cur_x = '0;
        cur_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (scan_idx == IDXW'(i)) begin
                cur_x = seg_x[i];
                cur_y = seg_y[i];
            end
        end
    end

    assign body_hit = (cur_x == nh_x) && (cur_y == nh_y);

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || init) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_WALL;
            S_WALL:  state_next = wall_hit ? S_DONE : S_SCAN;
            S_SCAN: begin
                if (body_hit) begin
                    state_next = S_DONE;
                end else if (scan_idx == scan_last) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_WALL) || (state == S_SCAN) || (state == S_SHIFT);
        done = (state == S_DONE);
        ate  = (state == S_DONE) && ate_r;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || init) begin
            length    <= IDXW'(INIT_LEN);
            heading   <= H_UP;
            dead      <= 1'b0;
            ate_r     <= 1'b0;
            nh_x      <= '0;
            nh_y      <= '0;
            wall_hit  <= 1'b0;
            scan_idx  <= '0;
            scan_last <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? 8'(X0) : 8'd0;
                seg_y[i] <= (i < INIT_LEN) ? 7'(Y0 + i * CELL) : 7'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        heading  <= eff_dir;
                        nh_x     <= cand_x;
                        nh_y     <= cand_y;
                        wall_hit <= cand_wall;
                        ate_r    <= 1'b0;
                    end
                end
                S_WALL: begin
                    if (wall_hit) begin
                        dead <= 1'b1;
                    end else begin
                        ate_r     <= ate_next;
                        scan_last <= last_next;
                        scan_idx  <= '0;
                    end
                end
                S_SCAN: begin
                    if (body_hit) begin
                        dead <= 1'b1;
                    end else begin
                        scan_idx <= scan_idx + IDXW'(1);
                    end
                end
                S_SHIFT: begin
                    seg_x[0] <= nh_x;
                    seg_y[0] <= nh_y;
                    // Slots past the new length are cleared so unused entries stay at (0,0).
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= (IDXW'(i) < new_len) ? seg_x[i-1] : 8'd0;
                        seg_y[i] <= (IDXW'(i) < new_len) ? seg_y[i-1] : 7'd0;
                    end
                    length <= new_len;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_valid = (rd_idx < length);
        rd_x     = '0;
        rd_y     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_valid && (rd_idx == IDXW'(i))) begin
                rd_x = seg_x[i];
                rd_y = seg_y[i];
            end
        end
    end

endmodule

// File: tb/tb_snake_body_store.sv
// Bench for snake_body_store: behavioural snake model plus a queue of expected step outcomes.
// Build with SNAKE_WRAP_EN defined to check the wrap-around variant.
module tb_snake_body_store;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       init     = 1'b0;
    logic       step     = 1'b0;
    logic [1:0] dir      = 2'b10;
    logic [7:0] apple_x  = 8'd200;
    logic [6:0] apple_y  = 7'd100;
    logic [3:0] rd_idx   = 4'd0;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_valid;
    logic [3:0] length;
    logic       busy;
    logic       done;
    logic       ate;
    logic       dead;

    int total = 0;
    int bad   = 0;

    // Scoreboard entry: {latency[7:0], 6'b0, ate, dead}
    logic [15:0] exp_q[$];

    int m_x[8];
    int m_y[8];
    int m_len;
    int m_hd;
    int m_dead;

    snake_body_store dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .init     (init),
        .step     (step),
        .dir      (dir),
        .apple_x  (apple_x),
        .apple_y  (apple_y),
        .rd_idx   (rd_idx),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_valid (rd_valid),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .ate      (ate),
        .dead     (dead)
    );

    always #20 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 8; i++) begin
            m_x[i] = (i < 4) ? 80 : 0;
            m_y[i] = (i < 4) ? 60 + 10 * i : 0;
        end
        m_len  = 4;
        m_hd   = 2;
        m_dead = 0;
    endtask

    // Next head for a requested direction, from the model's current head and heading.
    task automatic predict(input int d, output int nx, output int ny, output int wall, output int eff);
        int rev;
        rev = (d == 0 && m_hd == 3) || (d == 3 && m_hd == 0) ||
              (d == 1 && m_hd == 2) || (d == 2 && m_hd == 1);
        eff = rev ? m_hd : d;
        nx = m_x[0];
        ny = m_y[0];
        case (eff)
            0: nx = nx + 10;
            1: ny = ny + 10;
            2: ny = ny - 10;
            default: nx = nx - 10;
        endcase
        wall = 0;
`ifdef SNAKE_WRAP_EN
        if (nx < 0)   nx = 150;
        if (nx > 150) nx = 0;
        if (ny < 0)   ny = 110;
        if (ny > 110) ny = 0;
`else
        if (nx < 0 || nx > 150 || ny < 0 || ny > 110) wall = 1;
`endif
    endtask

    task automatic model_step(input int d, input int ax, input int ay,
                              output int lat, output int e_ate, output int e_dead);
        int nx, ny, wall, eff, last, hit_k;
        predict(d, nx, ny, wall, eff);
        m_hd   = eff;
        e_ate  = 0;
        e_dead = 0;
        if (wall != 0) begin
            e_dead = 1;
            m_dead = 1;
            lat    = 2;
        end else begin
            e_ate = (nx == ax && ny == ay) ? 1 : 0;
            last  = (e_ate != 0 && m_len < 8) ? m_len - 1 : m_len - 2;
            hit_k = -1;
            for (int k = 0; k <= last; k++) begin
                if (hit_k < 0 && m_x[k] == nx && m_y[k] == ny) hit_k = k;
            end
            if (hit_k >= 0) begin
                e_dead = 1;
                m_dead = 1;
                lat    = 3 + hit_k;
            end else begin
                lat = 3 + last + 1;
                for (int k = 7; k >= 1; k--) begin
                    m_x[k] = m_x[k-1];
                    m_y[k] = m_y[k-1];
                end
                m_x[0] = nx;
                m_y[0] = ny;
                if (e_ate != 0 && m_len < 8) m_len++;
            end
        end
    endtask

    task automatic check_body();
        int v;
        chk("length", 32'(length), m_len);
        chk("dead_level", 32'(dead), m_dead);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 4'(i);
            #1;
            v = (i < m_len) ? 1 : 0;
            chk($sformatf("seg%0d_valid", i), 32'(rd_valid), v);
            chk($sformatf("seg%0d_x", i), 32'(rd_x), (v != 0) ? m_x[i] : 0);
            chk($sformatf("seg%0d_y", i), 32'(rd_y), (v != 0) ? m_y[i] : 0);
        end
        rd_idx = 4'd15;
        #1;
        chk("idx15_valid", 32'(rd_valid), 0);
        chk("idx15_x", 32'(rd_x), 0);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        init   = 1'b0;
        step   = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        Resetn = 1'b1;
        model_init();
    endtask

    task automatic do_init();
        @(negedge CLOCK_50);
        init = 1'b1;
        @(negedge CLOCK_50);
        init = 1'b0;
        model_init();
    endtask

    task automatic do_step(input int d, input int ax, input int ay);
        int lat, ea, ed, cyc;
        logic [15:0] e;
        @(negedge CLOCK_50);
        dir     = 2'(d);
        apple_x = 8'(ax);
        apple_y = 7'(ay);
        model_step(d, ax, ay, lat, ea, ed);
        exp_q.push_back({8'(lat), 6'd0, 1'(ea), 1'(ed)});
        step = 1'b1;
        @(negedge CLOCK_50);
        step = 1'b0;
        cyc  = 1;
        chk("busy_after_step", 32'(busy), 1);
        while (!done && cyc < 40) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        e = exp_q.pop_front();
        chk("done_seen", 32'(done), 1);
        if (done) begin
            chk("latency", cyc, 32'(e[15:8]));
            chk("ate", 32'(ate), 32'(e[1]));
            chk("dead", 32'(dead), 32'(e[0]));
        end
        @(negedge CLOCK_50);
        chk("done_one_cycle", 32'(done), 0);
        chk("ate_one_cycle", 32'(ate), 0);
        check_body();
    endtask

    task automatic do_ignored_step(input int d);
        int saw;
        @(negedge CLOCK_50);
        dir  = 2'(d);
        step = 1'b1;
        @(negedge CLOCK_50);
        step = 1'b0;
        saw  = 0;
        repeat (8) begin
            if (done || busy) saw = 1;
            @(negedge CLOCK_50);
        end
        chk("ignored_step_activity", saw, 0);
        check_body();
    endtask

    initial begin
        int nx, ny, wall, eff, d, saw;

        do_reset();

        // Reset state
        @(negedge CLOCK_50);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ate", 32'(ate), 0);
        chk("rst_len", 32'(length), 4);
        rd_idx = 4'd3;
        #1;
        chk("rst_seg3_y", 32'(rd_y), 90);
        rd_idx = 4'd4;
        #1;
        chk("rst_idx4_valid", 32'(rd_valid), 0);
        check_body();

        // Plain step up, apple elsewhere
        do_step(2, 30, 30);
        rd_idx = 4'd0;
        #1;
        chk("up_head_x", 32'(rd_x), 80);
        chk("up_head_y", 32'(rd_y), 50);
        rd_idx = 4'd3;
        #1;
        chk("up_seg3_y", 32'(rd_y), 80);

        // Reversal (down while heading up) is rejected
        do_reset();
        do_step(1, 200, 100);
        rd_idx = 4'd0;
        #1;
        chk("rev_head_y", 32'(rd_y), 50);

        // Eat the apple and grow
        do_reset();
        do_step(2, 80, 50);
        chk("grow_len", 32'(length), 5);
        rd_idx = 4'd4;
        #1;
        chk("grow_seg4_y", 32'(rd_y), 90);

        // Run into the top wall (or wrap)
        do_init();
        repeat (6) do_step(2, 200, 100);
        do_step(2, 200, 100);
        for (int k = 0; k < 2; k++) begin
            if (m_dead != 0) do_ignored_step(2);
            else do_step(0, 200, 100);
        end

        // Length saturates at MAX_LEN while still reporting ate
        do_init();
        for (int k = 0; k < 5; k++) begin
            predict(2, nx, ny, wall, eff);
            do_step(2, nx, ny);
        end
        chk("sat_len", 32'(length), 8);

        // Self collision: length-5 snake turns right, down, left
        do_init();
        do_step(2, 80, 50);
        do_step(0, 200, 100);
        do_step(1, 200, 100);
        do_step(3, 200, 100);
        chk("selfcol_dead", 32'(dead), 1);
        do_ignored_step(0);

        // init during SCAN aborts the step and reloads the reset state
        do_init();
        @(negedge CLOCK_50);
        dir  = 2'b10;
        step = 1'b1;
        @(negedge CLOCK_50);
        step = 1'b0;
        @(negedge CLOCK_50);
        chk("abort_busy_in_scan", 32'(busy), 1);
        init = 1'b1;
        @(negedge CLOCK_50);
        init = 1'b0;
        model_init();
        saw = 0;
        repeat (10) begin
            if (done || busy) saw = 1;
            @(negedge CLOCK_50);
        end
        chk("abort_no_done", saw, 0);
        check_body();
        do_step(1, 200, 100);

        // step and init together: init wins
        @(negedge CLOCK_50);
        dir  = 2'b00;
        step = 1'b1;
        init = 1'b1;
        @(negedge CLOCK_50);
        step = 1'b0;
        init = 1'b0;
        model_init();
        saw = 0;
        repeat (8) begin
            if (done || busy) saw = 1;
            @(negedge CLOCK_50);
        end
        chk("init_wins", saw, 0);
        check_body();

        // Random walk with apples sometimes placed on the next head
        for (int k = 0; k < 20; k++) begin
            d = int'($urandom_range(0, 3));
            predict(d, nx, ny, wall, eff);
            if (m_dead != 0) begin
                if ($urandom_range(0, 1) == 0) do_init();
                else do_ignored_step(d);
            end else if (wall == 0 && $urandom_range(0, 1) == 1) begin
                do_step(d, nx, ny);
            end else begin
                do_step(d, 200, 100);
            end
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
